// File: rtl/branch_pkg.sv
// Shared types for the branch controller: FSM state encoding and stall-counter width.
package branch_pkg;

    localparam int STALL_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_STALL    = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: operand-hazard stall, taken evaluation and one-cycle redirect.
// Statistics counters are built only when BRANCH_STATS_EN is defined; otherwise the ports read 0.
module branch_ctrl #(
    parameter int INST_SZ = 32,
    parameter int STAT_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_branch,
    input  logic               i_bne,
    input  logic               i_comparison,
    input  logic [1:0]         i_stall_cycles,
    input  logic [INST_SZ-1:0] i_target,
    output logic               o_stall,
    output logic               o_pc_src,
    output logic [INST_SZ-1:0] o_pc_target,
    output logic               o_flush,
    output logic [STAT_W-1:0]  o_taken_count,
    output logic [STAT_W-1:0]  o_total_count
);
    import branch_pkg::*;

    state_t                 state;
    logic [STALL_CNT_W-1:0] cnt;
    logic                   eval;
    logic                   taken;

    assign taken = i_comparison ^ i_bne;

    // Evaluation happens once operands are valid: immediately for zero-stall
    // branches, otherwise in the first cycle after the stall has been served.
    always_comb begin
        eval = 1'b0;
        case (state)
            ST_IDLE:  eval = i_branch && (i_stall_cycles == 2'd0);
            ST_STALL: eval = i_branch && (cnt == '0);
            default:  eval = 1'b0;
        endcase
    end

    assign o_stall = i_rst_n &&
                     (((state == ST_IDLE) && i_branch && (i_stall_cycles != 2'd0)) ||
                      ((state == ST_STALL) && (cnt != '0)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_pc_src    <= 1'b0;
            o_flush     <= 1'b0;
            o_pc_target <= '0;
        end else begin
            o_pc_src <= 1'b0;
            o_flush  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (eval && taken) begin
                        state       <= ST_REDIRECT;
                        o_pc_src    <= 1'b1;
                        o_flush     <= 1'b1;
                        o_pc_target <= i_target;
                    end else if (i_branch && (i_stall_cycles != 2'd0)) begin
                        cnt   <= i_stall_cycles - 2'd1;
                        state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!i_branch) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (taken) begin
                        state       <= ST_REDIRECT;
                        o_pc_src    <= 1'b1;
                        o_flush     <= 1'b1;
                        o_pc_target <= i_target;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                // The slot behind a redirect is flushed, so i_branch is ignored here.
                ST_REDIRECT: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    sat_counter #(.W(STAT_W)) u_total_cnt (
        .clk   (i_clk),
        .clr_n (i_rst_n),
        .inc   (eval),
        .count (o_total_count)
    );

    sat_counter #(.W(STAT_W)) u_taken_cnt (
        .clk   (i_clk),
        .clr_n (i_rst_n),
        .inc   (eval && taken),
        .count (o_taken_count)
    );
`else
    assign o_total_count = '0;
    assign o_taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized scoreboard bench for branch_ctrl; expected statistics depend on BRANCH_STATS_EN.
module tb_branch_ctrl;

    localparam int INST_SZ = 32;
    localparam int STAT_W  = 4;
    localparam int SAT_MAX = (1 << STAT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               branch = 1'b0;
    logic               bne = 1'b0;
    logic               comparison = 1'b0;
    logic [1:0]         stall_cycles = 2'd0;
    logic [INST_SZ-1:0] target = '0;
    logic               stall;
    logic               pc_src;
    logic [INST_SZ-1:0] pc_target;
    logic               flush;
    logic [STAT_W-1:0]  taken_count;
    logic [STAT_W-1:0]  total_count;

    branch_ctrl #(.INST_SZ(INST_SZ), .STAT_W(STAT_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_branch       (branch),
        .i_bne          (bne),
        .i_comparison   (comparison),
        .i_stall_cycles (stall_cycles),
        .i_target       (target),
        .o_stall        (stall),
        .o_pc_src       (pc_src),
        .o_pc_target    (pc_target),
        .o_flush        (flush),
        .o_taken_count  (taken_count),
        .o_total_count  (total_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INST_SZ-1:0] tgt;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Reference model: a pending branch needs a given number of stall cycles,
    // then one evaluation; a taken evaluation yields one redirect next cycle.
    bit                 m_busy = 1'b0;
    int                 m_need = 0;
    int                 m_done = 0;
    bit                 m_pending = 1'b0;
    logic [INST_SZ-1:0] m_target = '0;
    int                 m_total = 0;
    int                 m_taken = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit r, input bit br, input bit sense, input bit cmp,
                         input int sc, input logic [INST_SZ-1:0] tgt);
        bit exp_stall;
        bit do_eval;
        @(negedge clk);
        rst_n        = r;
        branch       = br;
        bne          = sense;
        comparison   = cmp;
        stall_cycles = 2'(sc);
        target       = tgt;
        #1;
        exp_stall = 1'b0;
        do_eval   = 1'b0;
        if (!r) begin
            m_busy = 0; m_need = 0; m_done = 0; m_pending = 0;
            m_target = '0; m_total = 0; m_taken = 0;
        end else if (m_pending) begin
            m_pending = 0;
        end else if (m_busy) begin
            if (!br) begin
                exp_stall = (m_done < m_need);
                m_busy = 0;
            end else if (m_done < m_need) begin
                exp_stall = 1;
                m_done++;
            end else begin
                do_eval = 1;
                m_busy = 0;
            end
        end else if (br) begin
            if (sc == 0) begin
                do_eval = 1;
            end else begin
                exp_stall = 1;
                m_busy = 1;
                m_need = sc;
                m_done = 1;
            end
        end
        if (do_eval) begin
            if (m_total < SAT_MAX) m_total++;
            if (cmp ^ sense) begin
                if (m_taken < SAT_MAX) m_taken++;
                m_target  = tgt;
                m_pending = 1;
                sb.push_back('{tgt: tgt, cyc: cyc + 1});
            end
        end
        chk("o_stall", 64'(stall), 64'(exp_stall));
        @(posedge clk);
        #1;
        chk("o_pc_target", 64'(pc_target), 64'(m_target));
`ifdef BRANCH_STATS_EN
        chk("o_total_count", 64'(total_count), 64'(m_total));
        chk("o_taken_count", 64'(taken_count), 64'(m_taken));
`else
        chk("o_total_count", 64'(total_count), 64'd0);
        chk("o_taken_count", 64'(taken_count), 64'd0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, '0);
    endtask

    // Monitor: redirects must appear exactly at the cycle the scoreboard predicts.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (mon_en) begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    chk("redirect_cycle", 64'(cyc), 64'(e.cyc));
                    chk("o_pc_src", 64'(pc_src), 64'd1);
                    chk("o_flush", 64'(flush), 64'd1);
                    chk("redirect_target", 64'(pc_target), 64'(e.tgt));
                end else begin
                    chk("o_pc_src_quiet", 64'(pc_src), 64'd0);
                    chk("o_flush_quiet", 64'(flush), 64'd0);
                end
            end
        end
    end

    initial begin
        cycle(0, 1, 0, 1, 0, 32'hDEAD_BEEF);
        cycle(0, 1, 0, 1, 2, 32'h1234_5678);
        mon_en = 1'b1;
        idle(2);

        // BEQ zero-stall taken
        cycle(1, 1, 0, 1, 0, 32'h0000_0040);
        idle(3);
        // BNE not taken
        cycle(1, 1, 1, 1, 0, 32'h0000_0099);
        idle(2);
        // Three-cycle stall, operands valid after the stall
        cycle(1, 1, 0, 0, 3, 32'h0000_0100);
        cycle(1, 1, 0, 0, 3, 32'h0000_0100);
        cycle(1, 1, 0, 0, 3, 32'h0000_0100);
        cycle(1, 1, 0, 1, 3, 32'h0000_0100);
        idle(3);
        // Abort during stall
        cycle(1, 1, 0, 1, 2, 32'h0000_0200);
        cycle(1, 0, 0, 1, 2, 32'h0000_0200);
        idle(3);
        // Reset in the middle of a stall
        cycle(1, 1, 0, 1, 3, 32'h0000_0300);
        cycle(0, 1, 0, 1, 3, 32'h0000_0300);
        cycle(1, 0, 0, 1, 0, 32'h0000_0300);
        chk("reset_target", 64'(pc_target), 64'd0);
        idle(2);

        // Saturation: 20 taken branches, each followed by its redirect slot
        cycle(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 40; i++) cycle(1, 1, 0, 1, 0, 32'(i * 4));
        idle(2);
`ifdef BRANCH_STATS_EN
        chk("sat_taken", 64'(taken_count), 64'(SAT_MAX));
        chk("sat_total", 64'(total_count), 64'(SAT_MAX));
`endif

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 32'($urandom));
        end
        idle(4);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
